// File: rtl/hockey_pixel_renderer_pkg.sv
// Shared colour constants, reset-time object positions and the position-set
// record used by the air-hockey pixel renderer.
package hockey_pixel_renderer_pkg;

    localparam int RGB_W = 8;

    typedef logic [RGB_W-1:0] rgb_t;

    // RRRGGGBB palette.
    localparam rgb_t COL_BLANK  = 8'h00;
    localparam rgb_t COL_PUCK   = 8'hFF;
    localparam rgb_t COL_P1     = 8'hE0;
    localparam rgb_t COL_P2     = 8'h03;
    localparam rgb_t COL_BORDER = 8'h92;
    localparam rgb_t COL_CENTRE = 8'h49;
    localparam rgb_t COL_BG     = 8'h0C;
    localparam rgb_t COL_FLASH  = 8'hE4;

    typedef struct packed {
        logic [9:0] puck_x;
        logic [9:0] puck_y;
        logic [9:0] p1_x;
        logic [9:0] p1_y;
        logic [9:0] p2_x;
        logic [9:0] p2_y;
    } pos_set_t;

    localparam pos_set_t POS_RESET = '{
        puck_x: 10'd312, puck_y: 10'd232,
        p1_x:   10'd16,  p1_y:   10'd208,
        p2_x:   10'd616, p2_y:   10'd208
    };

endpackage

// File: rtl/hockey_box_hit.sv
// Combinational rectangle hit test; the far edges are formed in 11 bits so an
// object near coordinate 1023 cannot wrap around and claim pixels near 0.
module hockey_box_hit #(
    parameter int W = 16,
    parameter int H = 16
) (
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [9:0] obj_x_i,
    input  logic [9:0] obj_y_i,
    output logic       hit_o
);

    logic [10:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, obj_x_i} + 11'(W);
    assign y_end = {1'b0, obj_y_i} + 11'(H);

    assign hit_o = (x_i >= obj_x_i) && ({1'b0, x_i} < x_end) &&
                   (y_i >= obj_y_i) && ({1'b0, y_i} < y_end);

endmodule

// File: rtl/hockey_pixel_renderer.sv
// Two-stage air-hockey playfield pixel renderer with vblank-synchronised
// position commit. Optional background flash: define HOCKEY_GOAL_FLASH_EN.
module hockey_pixel_renderer
    import hockey_pixel_renderer_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int PUCK_SIZE = 16,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 64,
    parameter int BORDER    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic [9:0]       xpos,
    input  logic [9:0]       ypos,
    input  logic             pos_valid,
    input  logic [9:0]       puck_x,
    input  logic [9:0]       puck_y,
    input  logic [9:0]       p1_x,
    input  logic [9:0]       p1_y,
    input  logic [9:0]       p2_x,
    input  logic [9:0]       p2_y,
    input  logic             goal_flash,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_tick
);

    localparam logic [9:0] H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0] BRD_C    = 10'(BORDER);
    localparam logic [9:0] H_BRD_HI = 10'(H_ACTIVE - BORDER);
    localparam logic [9:0] V_BRD_HI = 10'(V_ACTIVE - BORDER);
    localparam logic [9:0] CTR_L    = 10'(H_ACTIVE / 2 - 1);
    localparam logic [9:0] CTR_R    = 10'(H_ACTIVE / 2);

    pos_set_t pend_q, pend_d, act_q, act_d;
    logic     pending_q, pending_d;
    logic     frame_tick_q;
    logic     commit;

    // Commit on the first pixel of vertical blanking, seen on the raw counters.
    assign commit = (xpos == 10'd0) && (ypos == V_ACT_C);

    always_comb begin
        pend_d    = pend_q;
        pending_d = pending_q;
        act_d     = act_q;
        if (commit && pending_q) begin
            act_d     = pend_q;
            pending_d = 1'b0;
        end
        // A strobe in the commit cycle lands in pending after the old set moved.
        if (pos_valid) begin
            pend_d    = '{puck_x: puck_x, puck_y: puck_y, p1_x: p1_x,
                          p1_y: p1_y, p2_x: p2_x, p2_y: p2_y};
            pending_d = 1'b1;
        end
    end

    logic puck_hit, p1_hit, p2_hit;

    hockey_box_hit #(.W(PUCK_SIZE), .H(PUCK_SIZE)) u_puck_hit (
        .x_i(xpos), .y_i(ypos), .obj_x_i(act_q.puck_x), .obj_y_i(act_q.puck_y), .hit_o(puck_hit)
    );
    hockey_box_hit #(.W(PAD_W), .H(PAD_H)) u_p1_hit (
        .x_i(xpos), .y_i(ypos), .obj_x_i(act_q.p1_x), .obj_y_i(act_q.p1_y), .hit_o(p1_hit)
    );
    hockey_box_hit #(.W(PAD_W), .H(PAD_H)) u_p2_hit (
        .x_i(xpos), .y_i(ypos), .obj_x_i(act_q.p2_x), .obj_y_i(act_q.p2_y), .hit_o(p2_hit)
    );

    logic in_active_d, border_d, centre_d;

    assign in_active_d = (xpos < H_ACT_C) && (ypos < V_ACT_C);
    assign border_d    = (xpos < BRD_C) || (xpos >= H_BRD_HI) ||
                         (ypos < BRD_C) || (ypos >= V_BRD_HI);
    assign centre_d    = (xpos == CTR_L) || (xpos == CTR_R);

    logic in_active_q, puck_hit_q, p1_hit_q, p2_hit_q, border_q, centre_q;
    logic hsync_s1_q, vsync_s1_q, hsync_s2_q, vsync_s2_q;
    rgb_t rgb_q, rgb_d, bg_col;

`ifdef HOCKEY_GOAL_FLASH_EN
    logic [3:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= 4'd0;
        end else if (frame_tick_q) begin
            frame_cnt_q <= frame_cnt_q + 4'd1;
        end
    end

    assign bg_col = (goal_flash && frame_cnt_q[3]) ? COL_FLASH : COL_BG;
`else
    logic unused_goal_flash;
    assign unused_goal_flash = goal_flash;
    assign bg_col            = COL_BG;
`endif

    always_comb begin
        rgb_d = bg_col;
        if (!in_active_q)    rgb_d = COL_BLANK;
        else if (puck_hit_q) rgb_d = COL_PUCK;
        else if (p1_hit_q)   rgb_d = COL_P1;
        else if (p2_hit_q)   rgb_d = COL_P2;
        else if (border_q)   rgb_d = COL_BORDER;
        else if (centre_q)   rgb_d = COL_CENTRE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q       <= POS_RESET;
            pending_q    <= 1'b0;
            act_q        <= POS_RESET;
            frame_tick_q <= 1'b0;
            in_active_q  <= 1'b0;
            puck_hit_q   <= 1'b0;
            p1_hit_q     <= 1'b0;
            p2_hit_q     <= 1'b0;
            border_q     <= 1'b0;
            centre_q     <= 1'b0;
            hsync_s1_q   <= 1'b1;
            vsync_s1_q   <= 1'b1;
            hsync_s2_q   <= 1'b1;
            vsync_s2_q   <= 1'b1;
            rgb_q        <= COL_BLANK;
        end else begin
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            act_q        <= act_d;
            frame_tick_q <= commit;
            in_active_q  <= in_active_d;
            puck_hit_q   <= puck_hit;
            p1_hit_q     <= p1_hit;
            p2_hit_q     <= p2_hit;
            border_q     <= border_d;
            centre_q     <= centre_d;
            hsync_s1_q   <= hsync_in;
            vsync_s1_q   <= vsync_in;
            hsync_s2_q   <= hsync_s1_q;
            vsync_s2_q   <= vsync_s1_q;
            rgb_q        <= rgb_d;
        end
    end

    assign rgb        = rgb_q;
    assign hsync_out  = hsync_s2_q;
    assign vsync_out  = vsync_s2_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hockey_pixel_renderer.sv
// Directed self-checking bench for hockey_pixel_renderer: reset, pipeline
// latency, deferred commit, commit collision, priority, clipping, mid-line reset.
module tb_hockey_pixel_renderer;

    logic       clk;
    logic       rst_n;
    logic       hsync_in, vsync_in;
    logic [9:0] xpos, ypos;
    logic       pos_valid;
    logic [9:0] puck_x, puck_y, p1_x, p1_y, p2_x, p2_y;
    logic       goal_flash;
    logic       hsync_out, vsync_out;
    logic [7:0] rgb;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    hockey_pixel_renderer dut (
        .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .xpos(xpos), .ypos(ypos), .pos_valid(pos_valid),
        .puck_x(puck_x), .puck_y(puck_y), .p1_x(p1_x), .p1_y(p1_y),
        .p2_x(p2_x), .p2_y(p2_y), .goal_flash(goal_flash),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb(rgb),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one pixel, hold it, and return rgb two clock edges later.
    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, output logic [7:0] got);
        @(negedge clk);
        xpos = x;
        ypos = y;
        @(negedge clk);
        @(negedge clk);
        got = rgb;
    endtask

    // Post the current position inputs mid-frame.
    task automatic strobe_pos();
        @(negedge clk);
        xpos      = 10'd5;
        ypos      = 10'd100;
        pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
    endtask

    // Present the commit pixel; report frame_tick one and two cycles later.
    task automatic do_commit(input logic with_strobe, output logic ft1, output logic ft2);
        @(negedge clk);
        xpos      = 10'd0;
        ypos      = 10'd480;
        pos_valid = with_strobe;
        @(negedge clk);
        ft1       = frame_tick;
        pos_valid = 1'b0;
        xpos      = 10'd1;
        @(negedge clk);
        ft2 = frame_tick;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        xpos     = 10'd320;
        ypos     = 10'd240;
        repeat (3) @(negedge clk);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb got %h exp 00", rgb); end
        checks++;
        if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++; $display("FAIL reset_sync got h%b v%b exp h1 v1", hsync_out, vsync_out);
        end
        checks++;
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        rst_n    = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
    endtask

    task automatic test_default_scene();
        logic [9:0] xs[9] = '{10'd320, 10'd312, 10'd311, 10'd327, 10'd328, 10'd319, 10'd20, 10'd620, 10'd700};
        logic [9:0] ys[9] = '{10'd240, 10'd232, 10'd232, 10'd247, 10'd247, 10'd100, 10'd210, 10'd210, 10'd100};
        logic [7:0] ex[9] = '{8'hFF, 8'hFF, 8'h0C, 8'hFF, 8'h0C, 8'h49, 8'hE0, 8'h03, 8'h00};
        logic [7:0] got;
        for (int i = 0; i < 9; i++) begin
            drive_pix(xs[i], ys[i], got);
            checks++;
            if (got !== ex[i]) begin
                errors++; $display("FAIL default_scene (%0d,%0d) got %h exp %h", xs[i], ys[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_latency_sync();
        logic [9:0] xs[8] = '{10'd320, 10'd0, 10'd100, 10'd700, 10'd319, 10'd20, 10'd620, 10'd328};
        logic [9:0] ys[8] = '{10'd240, 10'd240, 10'd100, 10'd10, 10'd300, 10'd220, 10'd210, 10'd247};
        logic       hs[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic       vs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] ex[8] = '{8'hFF, 8'h92, 8'h0C, 8'h00, 8'h49, 8'hE0, 8'h03, 8'h0C};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (rgb !== ex[i-2] || hsync_out !== hs[i-2] || vsync_out !== vs[i-2]) begin
                    errors++;
                    $display("FAIL latency step %0d got rgb %h h%b v%b exp rgb %h h%b v%b",
                             i - 2, rgb, hsync_out, vsync_out, ex[i-2], hs[i-2], vs[i-2]);
                end
            end
            if (i < 8) begin
                xpos = xs[i]; ypos = ys[i]; hsync_in = hs[i]; vsync_in = vs[i];
            end else begin
                hsync_in = 1'b1; vsync_in = 1'b1;
            end
        end
    endtask

    task automatic test_deferred_commit();
        logic [7:0] got;
        logic ft1, ft2;
        puck_x = 10'd100; puck_y = 10'd50;
        strobe_pos();
        drive_pix(10'd320, 10'd240, got);
        checks++;
        if (got !== 8'hFF) begin errors++; $display("FAIL defer_old_puck got %h exp FF", got); end
        drive_pix(10'd100, 10'd50, got);
        checks++;
        if (got !== 8'h0C) begin errors++; $display("FAIL defer_new_early got %h exp 0C", got); end
        do_commit(1'b0, ft1, ft2);
        checks++;
        if (ft1 !== 1'b1 || ft2 !== 1'b0) begin
            errors++; $display("FAIL defer_tick got %b%b exp 10", ft1, ft2);
        end
        drive_pix(10'd100, 10'd50, got);
        checks++;
        if (got !== 8'hFF) begin errors++; $display("FAIL defer_new_puck got %h exp FF", got); end
        drive_pix(10'd116, 10'd65, got);
        checks++;
        if (got !== 8'h0C) begin errors++; $display("FAIL defer_puck_edge got %h exp 0C", got); end
        drive_pix(10'd320, 10'd240, got);
        checks++;
        if (got !== 8'h49) begin errors++; $display("FAIL defer_old_gone got %h exp 49", got); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got;
        logic ft1, ft2;
        puck_x = 10'd10; puck_y = 10'd10;
        strobe_pos();
        puck_x = 10'd200; puck_y = 10'd200;
        do_commit(1'b1, ft1, ft2);
        checks++;
        if (ft1 !== 1'b1 || ft2 !== 1'b0) begin errors++; $display("FAIL b2b_tick1 got %b%b exp 10", ft1, ft2); end
        drive_pix(10'd10, 10'd10, got);
        checks++;
        if (got !== 8'hFF) begin errors++; $display("FAIL b2b_first_puck got %h exp FF", got); end
        drive_pix(10'd200, 10'd200, got);
        checks++;
        if (got !== 8'h0C) begin errors++; $display("FAIL b2b_second_early got %h exp 0C", got); end
        do_commit(1'b0, ft1, ft2);
        checks++;
        if (ft1 !== 1'b1 || ft2 !== 1'b0) begin errors++; $display("FAIL b2b_tick2 got %b%b exp 10", ft1, ft2); end
        drive_pix(10'd200, 10'd200, got);
        checks++;
        if (got !== 8'hFF) begin errors++; $display("FAIL b2b_second_puck got %h exp FF", got); end
        drive_pix(10'd10, 10'd10, got);
        checks++;
        if (got !== 8'h0C) begin errors++; $display("FAIL b2b_first_gone got %h exp 0C", got); end
    endtask

    task automatic test_border_overlap();
        logic [9:0] xs[4] = '{10'd2, 10'd0, 10'd7, 10'd3};
        logic [9:0] ys[4] = '{10'd2, 10'd100, 10'd63, 10'd64};
        logic [7:0] ex[4] = '{8'hE0, 8'h92, 8'hE0, 8'h92};
        logic [7:0] got;
        logic ft1, ft2;
        p1_x = 10'd0; p1_y = 10'd0;
        strobe_pos();
        do_commit(1'b0, ft1, ft2);
        for (int i = 0; i < 4; i++) begin
            drive_pix(xs[i], ys[i], got);
            checks++;
            if (got !== ex[i]) begin
                errors++; $display("FAIL border_overlap (%0d,%0d) got %h exp %h", xs[i], ys[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_edge_clip();
        logic [9:0] xs[3] = '{10'd639, 10'd640, 10'd1021};
        logic [9:0] ys[3] = '{10'd475, 10'd475, 10'd471};
        logic [7:0] ex[3] = '{8'h92, 8'h00, 8'h00};
        logic [7:0] got, want;
        logic ft1, ft2;
        puck_x = 10'd1020; puck_y = 10'd470;
        strobe_pos();
        do_commit(1'b0, ft1, ft2);
        for (int x = 0; x < 16; x++) begin
            drive_pix(10'(x), 10'd475, got);
            want = (x < 4) ? 8'h92 : 8'h0C;
            checks++;
            if (got !== want) begin
                errors++; $display("FAIL edge_low_x (%0d,475) got %h exp %h", x, got, want);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_pix(xs[i], ys[i], got);
            checks++;
            if (got !== ex[i]) begin
                errors++; $display("FAIL edge_clip (%0d,%0d) got %h exp %h", xs[i], ys[i], got, ex[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got;
        logic ft1, ft2;
        puck_x = 10'd50; puck_y = 10'd50;
        strobe_pos();
        @(negedge clk);
        xpos = 10'd300; ypos = 10'd100; hsync_in = 1'b0; vsync_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rgb !== 8'h00 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got rgb %h h%b v%b exp rgb 00 h1 v1", rgb, hsync_out, vsync_out);
        end
        rst_n = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        drive_pix(10'd320, 10'd240, got);
        checks++;
        if (got !== 8'hFF) begin errors++; $display("FAIL mid_reset_puck got %h exp FF", got); end
        drive_pix(10'd20, 10'd210, got);
        checks++;
        if (got !== 8'hE0) begin errors++; $display("FAIL mid_reset_p1 got %h exp E0", got); end
        do_commit(1'b0, ft1, ft2);
        checks++;
        if (ft1 !== 1'b1) begin errors++; $display("FAIL mid_reset_tick got %b exp 1", ft1); end
        drive_pix(10'd50, 10'd50, got);
        checks++;
        if (got !== 8'h0C) begin errors++; $display("FAIL mid_reset_pending got %h exp 0C", got); end
        drive_pix(10'd620, 10'd210, got);
        checks++;
        if (got !== 8'h03) begin errors++; $display("FAIL mid_reset_p2 got %h exp 03", got); end
    endtask

    initial begin
        rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        xpos = 10'd0; ypos = 10'd0; pos_valid = 1'b0;
        puck_x = 10'd312; puck_y = 10'd232;
        p1_x = 10'd16; p1_y = 10'd208;
        p2_x = 10'd616; p2_y = 10'd208;
        goal_flash = 1'b1;
        test_reset();
        test_default_scene();
        test_latency_sync();
        test_deferred_commit();
        test_back_to_back();
        test_border_overlap();
        test_edge_clip();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
